// File: rtl/jtframe_sdram_share.sv
// jtframe_sdram_share: arbitrates one SDRAM bank port between the game (priority) and an aux engine.
// Define JTFRAME_SDRAM_SHARE_TIMEOUT_EN to add a grant-to-ba_rdy watchdog and the sticky aux_err flag.
module jtframe_sdram_share #(
    parameter int AW      = 22,
    parameter int MAXWAIT = 4,
    parameter int TOUT    = 255
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] game_addr,
    input  logic          game_rd,
    input  logic          game_wr,
    input  logic [15:0]   game_din,
    input  logic [1:0]    game_din_m,
    output logic          game_ack,
    output logic          game_dst,
    output logic          game_rdy,
    input  logic [AW-1:0] aux_addr,
    input  logic          aux_we,
    input  logic [15:0]   aux_din,
    input  logic [1:0]    aux_din_m,
    input  logic          aux_req,
    output logic          aux_busy,
    output logic          aux_done,
    output logic [15:0]   aux_dout,
    output logic          aux_err,
    output logic [AW-1:0] ba_addr,
    output logic          ba_rd,
    output logic          ba_wr,
    output logic [15:0]   ba_din,
    output logic [1:0]    ba_din_m,
    input  logic          ba_ack,
    input  logic          ba_dst,
    input  logic          ba_rdy,
    input  logic [15:0]   data_read
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GAME  = 2'd1;
    localparam logic [1:0] S_AREQ  = 2'd2;
    localparam logic [1:0] S_AWAIT = 2'd3;
    localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

    logic [1:0]    r_state, w_next;
    logic          r_pend, r_we, r_done;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_din, r_dout;
    logic [1:0]    r_din_m;
    logic [3:0]    r_wait;
    logic          w_game_req, w_starve, w_aux_own, w_accept;
    logic          w_aux_fin, w_tout, w_aux_end;

    assign w_game_req = game_rd | game_wr;
    assign w_starve   = r_pend && (r_wait == WAIT_MAX);
    assign w_aux_own  = (r_state == S_AREQ) || (r_state == S_AWAIT);
    assign w_accept   = aux_req && !r_pend;
    assign w_aux_fin  = ba_rdy && ((r_state == S_AWAIT) || (r_state == S_AREQ && ba_ack));
    assign w_aux_end  = w_aux_fin || (w_tout && w_aux_own);

`ifdef JTFRAME_SDRAM_SHARE_TIMEOUT_EN
    localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);
    logic [7:0] r_tcnt;
    logic       r_err;

    // Counter rests at zero in IDLE, so every grant starts counting from zero
    assign w_tout  = (r_state != S_IDLE) && !ba_rdy && (r_tcnt == TOUT_LAST);
    assign aux_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= (r_state == S_IDLE) ? 8'd0 : r_tcnt + 8'd1;
            if (w_accept)
                r_err <= 1'b0;
            else if (w_tout && w_aux_own)
                r_err <= 1'b1;
        end
    end
`else
    // Keeps TOUT referenced in builds without the watchdog
    logic [7:0] w_unused_tout;
    assign w_unused_tout = 8'(TOUT);
    assign w_tout        = 1'b0;
    assign aux_err       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_starve)        w_next = S_AREQ;
                     else if (w_game_req) w_next = S_GAME;
                     else if (r_pend)     w_next = S_AREQ;
            S_GAME:  if (ba_rdy)          w_next = S_IDLE;
            S_AREQ:  if (ba_ack && ba_rdy) w_next = S_IDLE;
                     else if (ba_ack)     w_next = S_AWAIT;
            default: if (ba_rdy)          w_next = S_IDLE;
        endcase
        if (w_tout)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_din   <= 16'd0;
            r_din_m <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pend  <= 1'b1;
                r_addr  <= aux_addr;
                r_we    <= aux_we;
                r_din   <= aux_din;
                r_din_m <= aux_din_m;
            end else if (w_aux_end) begin
                r_pend  <= 1'b0;
            end
        end
    end

    // wait_cnt only counts game grants taken while aux is already latched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_dout <= 16'd0;
            r_wait <= 4'd0;
        end else begin
            r_done <= w_aux_end;
            if (w_aux_own && !r_we && ba_dst)
                r_dout <= data_read;
            if (w_aux_end)
                r_wait <= 4'd0;
            else if (r_state == S_IDLE && !w_starve && w_game_req && r_pend && r_wait != WAIT_MAX)
                r_wait <= r_wait + 4'd1;
        end
    end

    assign ba_addr  = w_aux_own ? r_addr  : game_addr;
    assign ba_din   = w_aux_own ? r_din   : game_din;
    assign ba_din_m = w_aux_own ? r_din_m : game_din_m;
    assign ba_rd    = (r_state == S_GAME) ? game_rd : ((r_state == S_AREQ) && !r_we);
    assign ba_wr    = (r_state == S_GAME) ? game_wr : ((r_state == S_AREQ) &&  r_we);

    assign game_ack = (r_state == S_GAME) && ba_ack;
    assign game_dst = (r_state == S_GAME) && ba_dst;
    assign game_rdy = (r_state == S_GAME) && ba_rdy;

    assign aux_busy = r_pend;
    assign aux_done = r_done;
    assign aux_dout = r_dout;
endmodule

// File: tb/tb_jtframe_sdram_share.sv
// Directed bench for jtframe_sdram_share: grant order and aux results are checked against queues.
// Build with JTFRAME_SDRAM_SHARE_TIMEOUT_EN defined to also exercise the watchdog.
module tb_jtframe_sdram_share;
    localparam int AW = 22;
    localparam logic [AW-1:0] GADDR = 22'h3000A0;
    localparam logic [AW-1:0] AUXA  = 22'h001234;
    localparam logic [AW-1:0] AUXB  = 22'h002BAD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] game_addr = '0, aux_addr = '0, ba_addr;
    logic          game_rd = 1'b0, game_wr = 1'b0, aux_we = 1'b0, aux_req = 1'b0;
    logic [15:0]   game_din = 16'h0, aux_din = 16'h0, data_read = 16'h0;
    logic [1:0]    game_din_m = 2'd0, aux_din_m = 2'd0;
    logic          ba_ack = 1'b0, ba_dst = 1'b0, ba_rdy = 1'b0;
    logic          game_ack, game_dst, game_rdy, aux_busy, aux_done, aux_err;
    logic          ba_rd, ba_wr;
    logic [15:0]   aux_dout, ba_din;
    logic [1:0]    ba_din_m;

    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] grantQ[$];
    logic [15:0]   doneQ[$];
    logic [15:0]   bankData = 16'h0;

    always #5 clk = ~clk;

    jtframe_sdram_share #(.AW(AW), .MAXWAIT(4), .TOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .game_addr(game_addr), .game_rd(game_rd), .game_wr(game_wr),
        .game_din(game_din), .game_din_m(game_din_m),
        .game_ack(game_ack), .game_dst(game_dst), .game_rdy(game_rdy),
        .aux_addr(aux_addr), .aux_we(aux_we), .aux_din(aux_din), .aux_din_m(aux_din_m),
        .aux_req(aux_req), .aux_busy(aux_busy), .aux_done(aux_done),
        .aux_dout(aux_dout), .aux_err(aux_err),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din), .ba_din_m(ba_din_m),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy), .data_read(data_read)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the game/aux requesters and a bank that acks at age 1 and completes at age 3
    task automatic applyStimulus(input int gameN, input int auxAt, input int aux2At,
                                 input int reissue, input int maxCyc);
        int gameLeft = gameN;
        int reLeft = reissue;
        bit bankBusy = 1'b0;
        int age = 0;
        game_addr = GADDR;
        for (int cyc = 0; cyc < maxCyc; cyc++) begin
            game_rd = (gameLeft > 0);
            aux_req = 1'b0;
            if (aux_done) begin
                checkOutput("aux_done_expected", 32'(doneQ.size() > 0), 32'd1);
                if (doneQ.size() > 0)
                    checkOutput("aux_dout", 32'(aux_dout), 32'(doneQ.pop_front()));
                checkOutput("aux_busy_at_done", 32'(aux_busy), 32'd0);
            end
            if (cyc == auxAt) begin
                aux_req = 1'b1; aux_addr = AUXA; aux_we = 1'b0;
                doneQ.push_back(bankData);
            end else if (cyc == aux2At) begin
                aux_req = 1'b1; aux_addr = AUXB; aux_we = 1'b0;
            end else if (aux_done && reLeft > 0) begin
                aux_req = 1'b1; aux_addr = AUXA; aux_we = 1'b0;
                reLeft--;
                doneQ.push_back(bankData);
            end
            #1;
            if (!bankBusy && (ba_rd || ba_wr)) begin
                bankBusy = 1'b1;
                age = 0;
                checkOutput("grant_expected", 32'(grantQ.size() > 0), 32'd1);
                if (grantQ.size() > 0)
                    checkOutput("grant_addr", 32'(ba_addr), 32'(grantQ.pop_front()));
            end
            ba_ack = bankBusy && (age == 1);
            ba_rdy = bankBusy && (age == 3);
            ba_dst = ba_rdy;
            data_read = ba_rdy ? bankData : 16'h0;
            @(negedge clk);
            if (game_rdy) gameLeft--;
            if (bankBusy) begin
                if (age == 3) bankBusy = 1'b0;
                else age++;
            end
            nextCycle();
            if (grantQ.size() == 0 && doneQ.size() == 0 && !bankBusy && gameLeft <= 0 &&
                reLeft == 0 && cyc >= auxAt && cyc >= aux2At)
                break;
        end
        game_rd = 1'b0; aux_req = 1'b0;
        ba_ack = 1'b0; ba_rdy = 1'b0; ba_dst = 1'b0; data_read = 16'h0;
        checkOutput("stimulus_drained", 32'(grantQ.size() + doneQ.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values while rst_n is held low
        game_addr = GADDR;
        #2;
        checkOutput("rst_ba_rd", 32'(ba_rd), 32'd0);
        checkOutput("rst_ba_wr", 32'(ba_wr), 32'd0);
        checkOutput("rst_aux_busy", 32'(aux_busy), 32'd0);
        checkOutput("rst_aux_done", 32'(aux_done), 32'd0);
        checkOutput("rst_aux_dout", 32'(aux_dout), 32'd0);
        checkOutput("rst_aux_err", 32'(aux_err), 32'd0);
        checkOutput("rst_ba_addr_game", 32'(ba_addr), 32'(GADDR));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Game read: grant one cycle later, ack at +2, rdy at +5
        game_rd = 1'b1;
        @(negedge clk);
        checkOutput("t1_idle_latency", 32'(ba_rd), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1_grant_ba_rd", 32'(ba_rd), 32'd1);
        checkOutput("t1_no_early_ack", 32'(game_ack), 32'd0);
        nextCycle();
        ba_ack = 1'b1;
        @(negedge clk);
        checkOutput("t1_game_ack", 32'(game_ack), 32'd1);
        nextCycle();
        ba_ack = 1'b0;
        nextCycle();
        nextCycle();
        ba_rdy = 1'b1; ba_dst = 1'b1;
        @(negedge clk);
        checkOutput("t1_game_rdy", 32'(game_rdy), 32'd1);
        checkOutput("t1_game_dst", 32'(game_dst), 32'd1);
        checkOutput("t1_aux_busy", 32'(aux_busy), 32'd0);
        nextCycle();
        ba_rdy = 1'b0; ba_dst = 1'b0; game_rd = 1'b0;
        @(negedge clk);
        checkOutput("t1_back_idle", 32'(ba_rd), 32'd0);
        checkOutput("t1_rdy_gated", 32'(game_rdy), 32'd0);

        // Aux read of 0x1234 returning 0xBEEF
        nextCycle();
        aux_addr = AUXA; aux_we = 1'b0; aux_req = 1'b1;
        doneQ.push_back(16'hBEEF);
        @(negedge clk);
        checkOutput("t2_busy_not_yet", 32'(aux_busy), 32'd0);
        nextCycle();
        aux_req = 1'b0; aux_addr = AUXB;
        @(negedge clk);
        checkOutput("t2_busy", 32'(aux_busy), 32'd1);
        checkOutput("t2_decision_cycle", 32'(ba_rd), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t2_areq_rd", 32'(ba_rd), 32'd1);
        checkOutput("t2_areq_addr", 32'(ba_addr), 32'(AUXA));
        nextCycle();
        ba_ack = 1'b1;
        @(negedge clk);
        checkOutput("t2_rd_held_on_ack", 32'(ba_rd), 32'd1);
        checkOutput("t2_game_ack_gated", 32'(game_ack), 32'd0);
        nextCycle();
        ba_ack = 1'b0;
        @(negedge clk);
        checkOutput("t2_rd_low_after_ack", 32'(ba_rd), 32'd0);
        nextCycle();
        ba_dst = 1'b1; ba_rdy = 1'b1; data_read = 16'hBEEF;
        @(negedge clk);
        checkOutput("t2_done_not_yet", 32'(aux_done), 32'd0);
        nextCycle();
        ba_dst = 1'b0; ba_rdy = 1'b0; data_read = 16'h0;
        @(negedge clk);
        checkOutput("t2_done", 32'(aux_done), 32'd1);
        checkOutput("t2_busy_falls", 32'(aux_busy), 32'd0);
        checkOutput("t2_dout", 32'(aux_dout), 32'(doneQ.pop_front()));
        nextCycle();
        @(negedge clk);
        checkOutput("t2_done_single", 32'(aux_done), 32'd0);
        nextCycle();

        // Continuous game with aux pending: 4 counted game grants, then aux, twice over
        bankData = 16'h5A01;
        repeat (5) grantQ.push_back(GADDR);
        grantQ.push_back(AUXA);
        repeat (5) grantQ.push_back(GADDR);
        grantQ.push_back(AUXA);
        applyStimulus(10, 2, -1, 1, 200);

        // Same-cycle requests: game first, aux next, busy-time aux_req ignored
        bankData = 16'h7E02;
        grantQ.push_back(GADDR);
        grantQ.push_back(AUXA);
        applyStimulus(1, 0, 3, 0, 60);

        // Reset asserted in the middle of an aux write
        aux_addr = AUXA; aux_we = 1'b1; aux_din = 16'h1111; aux_req = 1'b1;
        nextCycle();
        aux_req = 1'b0;
        nextCycle();
        ba_ack = 1'b1;
        @(negedge clk);
        checkOutput("t5_areq_wr", 32'(ba_wr), 32'd1);
        nextCycle();
        ba_ack = 1'b0;
        @(negedge clk);
        checkOutput("t5_busy_in_wait", 32'(aux_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_ba_rd", 32'(ba_rd), 32'd0);
        checkOutput("t5_rst_ba_wr", 32'(ba_wr), 32'd0);
        checkOutput("t5_rst_busy", 32'(aux_busy), 32'd0);
        checkOutput("t5_rst_done", 32'(aux_done), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        bankData = 16'hC0DE;
        grantQ.push_back(AUXA);
        applyStimulus(0, 0, -1, 0, 60);

`ifdef JTFRAME_SDRAM_SHARE_TIMEOUT_EN
        // Aux write that never completes: watchdog fires 16 cycles after the grant
        begin
            int gc = -1;
            int dc = -1;
            aux_addr = AUXB; aux_we = 1'b1; aux_din = 16'h2222; aux_req = 1'b1;
            for (int c = 0; c < 60; c++) begin
                if (c == 1) aux_req = 1'b0;
                #1;
                if (gc < 0 && ba_wr) gc = c;
                ba_ack = (gc >= 0) && (c == gc + 1);
                if (aux_done) begin
                    dc = c;
                    break;
                end
                @(negedge clk);
                nextCycle();
            end
            ba_ack = 1'b0;
            checkOutput("t6_timeout_latency", 32'(dc - gc), 32'd16);
            checkOutput("t6_err_set", 32'(aux_err), 32'd1);
            checkOutput("t6_busy_clear", 32'(aux_busy), 32'd0);
            checkOutput("t6_dout_kept", 32'(aux_dout), 32'(16'hC0DE));
            nextCycle();
            bankData = 16'h3C3C;
            grantQ.push_back(AUXA);
            applyStimulus(0, 0, -1, 0, 60);
            checkOutput("t6_err_cleared", 32'(aux_err), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtframe_sdram_share.md
Name: jtframe_sdram_share

Overview:
- Two-requester arbiter for one SDRAM bank port.
- Primary requester: the game, which has priority. Auxiliary requester: a helper engine such as the cheat CPU or a debugger, issuing single 16-bit accesses.
- Sits between the game/helper and the SDRAM controller's bank-0 port.
- Replaces ad-hoc owner muxing with an explicit FSM, auxiliary request latching and anti-starvation.

Parameters:
- AW, 22, SDRAM word address width.
- MAXWAIT, 4, consecutive game grants tolerated while aux is pending before aux is forced in (1..15).
- TOUT, 255, cycles allowed between grant and ba_rdy (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous reset, active low
- game_addr  in  AW  game address
- game_rd  in  1  game read request, level, held until game_rdy
- game_wr  in  1  game write request, level, held until game_rdy
- game_din  in  16  game write data
- game_din_m  in  2  game byte mask
- game_ack  out  1  bank ack forwarded to game
- game_dst  out  1  bank data strobe forwarded to game
- game_rdy  out  1  bank ready forwarded to game
- aux_addr  in  AW  aux address, sampled on aux_req
- aux_we  in  1  1 = write, sampled on aux_req
- aux_din  in  16  aux write data, sampled on aux_req
- aux_din_m  in  2  aux byte mask, sampled on aux_req
- aux_req  in  1  one-cycle request strobe
- aux_busy  out  1  aux request pending or in flight
- aux_done  out  1  one-cycle pulse when the aux access completes
- aux_dout  out  16  read data captured on ba_dst
- aux_err  out  1  sticky timeout flag; cleared by the next accepted aux_req
- ba_addr  out  AW  bank address
- ba_rd  out  1  bank read request
- ba_wr  out  1  bank write request
- ba_din  out  16  bank write data
- ba_din_m  out  2  bank byte mask
- ba_ack  in  1  controller accepted the request
- ba_dst  in  1  read data valid on data_read
- ba_rdy  in  1  access complete
- data_read  in  16  bank read data

Behaviour:
- Reset (async, rst_n low): state IDLE, owner = game. All registered outputs 0: aux_busy, aux_done, aux_dout, aux_err, internal request latch, wait_cnt. ba_rd/ba_wr are 0 immediately because the state is IDLE.
- Aux capture:
  - An aux_req with aux_busy=0 latches addr/we/din/din_m and sets pend; aux_busy=1 from the next cycle.
  - aux_req while aux_busy=1 is ignored.
- FSM states: IDLE, GAME, AUX_REQ, AUX_WAIT.
- IDLE:
  - starve = pend && wait_cnt==MAXWAIT.
  - If starve → AUX_REQ.
  - Else if game_rd|game_wr → GAME, and wait_cnt += pend (saturating at MAXWAIT).
  - Else if pend → AUX_REQ.
  - Otherwise stay. The grant decision costs one cycle of latency.
- GAME:
  - ba_* = game_* combinationally; game_ack/dst/rdy = ba_ack/dst/rdy. Aux sees nothing.
  - On ba_rdy → IDLE. Game dropping rd/wr early does not end the state; only ba_rdy does.
- AUX_REQ:
  - ba_addr/din/din_m from the latch; ba_rd = ~we, ba_wr = we.
  - On ba_ack → AUX_WAIT, with ba_rd/ba_wr low from the next cycle.
  - ba_ack and ba_rdy in the same cycle → treat as completion directly.
- AUX_WAIT:
  - ba_dst → aux_dout <= data_read (reads only; aux_dout holds its value on writes).
  - ba_rdy → IDLE; pend=0, aux_busy=0, aux_done=1 for exactly one cycle; wait_cnt=0.
- game_ack/dst/rdy are 0 whenever the state is not GAME.
- In IDLE, ba_* data lines present game values with rd/wr low.
- A new aux_req may be accepted in the same cycle aux_done is high.
- Both requesters asking in the same IDLE cycle: game wins unless starve.

Optional Feature:
- Macro: JTFRAME_SDRAM_SHARE_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter is cleared on entry to GAME or AUX_REQ and increments each cycle in GAME/AUX_REQ/AUX_WAIT.
  - Reaching TOUT without ba_rdy forces IDLE.
  - If the owner was aux: aux_err=1 (sticky), aux_done pulses, aux_busy clears, aux_dout unchanged.
  - If the owner was game: no flag; game_rdy is not generated.
- Without the macro: no counter; aux_err is tied 0 and the FSM waits indefinitely for ba_rdy.

Test Plan:
- Idle bank, game_rd with ba_ack at +2 and ba_rdy at +5 → state GAME one cycle after game_rd; game_rdy asserts in the ba_rdy cycle; aux_busy stays 0.
- aux_req read of addr 0x1234 with no game activity; bank returns data_read 0xBEEF on ba_dst → ba_rd high until ba_ack then low; aux_dout=0xBEEF; aux_done single pulse; aux_busy falls the same cycle.
- Game requests back-to-back continuously, aux pending, MAXWAIT=4 → exactly 4 game grants, then the aux grant; wait_cnt back to 0 afterward.
- aux_req and game_rd in the same cycle with wait_cnt=0 → game served first, aux next; second aux_req during busy ignored (aux_addr change not seen on ba_addr).
- Assert rst_n low mid AUX_WAIT → ba_rd/ba_wr, aux_busy, aux_done immediately 0; after release, IDLE and a fresh aux_req completes normally.
- Macro defined, TOUT=16, bank never asserts ba_rdy on an aux write → aux_done and aux_err at cycle 16 after grant; next aux_req clears aux_err.
